// File: rtl/alu_rr_scheduler_pkg.sv
// Shared types for the round-robin ALU scheduler: opcodes, FSM states, widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_rr_scheduler_pkg;

  localparam int OP_W     = 3;
  localparam int OP_CNT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } sched_state_e;

  // Requester ID width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between client blocks and the ALU scheduler.
// Latency: wires only.
// Backpressure: valid/ready per requester on the request side, single valid/ready on the response side.
interface alu_rr_scheduler_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  import alu_rr_scheduler_pkg::*;

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]  req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_zero;

  // Client side: raises requests, consumes responses.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: en low forces an empty grant; the caller decides when a pick is taken.
module alu_rr_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    first;
  logic [ID_W:0]      sum;

  // Rotate so ptr sits at bit 0, find the lowest set bit, then rotate the index back.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    first = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) first = ID_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, first};
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    vld   = en && (|req);
    idx   = vld ? sum[ID_W-1:0] : '0;
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = vld && (idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU among NUM_REQ requesters, round-robin, one op in flight.
// Latency: request accept -> rsp_valid two cycles later; at least three cycles per op.
// Backpressure: response held stable until rsp_ready; no new grant until back in IDLE.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_rr_scheduler_if.slave   bus,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero,
  output logic [OP_CNT_W-1:0] op_count
);

  localparam int ID_W = id_w(NUM_REQ);

  sched_state_e       state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    op_id;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rsp_id_q;
  logic [NUM_REQ-1:0] grant;
  logic               grant_vld;
  logic               arb_en;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   rsp_result_q;
  logic [OP_W-1:0]    op_code;
  logic [OP_W-1:0]    sel_op;
  logic               rsp_valid_q;
  logic               rsp_zero_q;

  // Grants only in IDLE; held off while reset is asserted so req_ready reads 0 in reset.
  assign arb_en = (state == IDLE) && rst_n;

  alu_rr_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (grant_idx),
    .vld   (grant_vld)
  );

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

  // ALU inputs always come from the operand registers, so they hold between ops.
  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;

  // Select the winning requester's payload with the one-hot grant.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = bus.req_a[i*WIDTH +: WIDTH];
        sel_b  = bus.req_b[i*WIDTH +: WIDTH];
        sel_op = bus.req_op[i*OP_W +: OP_W];
      end
    end
  end

  // Scheduler FSM: latch winner in IDLE, capture ALU in ISSUE, hold response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_code      <= '0;
      op_id        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_code <= sel_op;
            op_id   <= grant_idx;
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          rsp_id_q     <= op_id;
          rsp_valid_q  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count    <= op_count + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: vector table, scoreboard and corner sequences.
// Latency: checks accept -> response in exactly two cycles.
// Backpressure: exercises held responses, mid-op reset and counter wrap.
module tb_alu_rr_scheduler;
  import alu_rr_scheduler_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int NV = 10;

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         zero;
  } vec_t;

  typedef struct {
    int         id;
    logic [W:0] zr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.WIDTH(W), .NUM_REQ(N)) bus();

  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         alu_zero;
  logic [15:0]  op_count;

  alu_rr_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .op_count   (op_count)
  );

  logic [N-1:0] drv_valid;
  logic [W-1:0] drv_a [N];
  logic [W-1:0] drv_b [N];
  logic [2:0]   drv_op [N];
  logic         rsp_rdy;
  logic         preset_req;

  always_comb begin
    bus.req_valid = drv_valid;
    bus.rsp_ready = rsp_rdy;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = drv_a[i];
      bus.req_b[i*W +: W] = drv_b[i];
      bus.req_op[i*3 +: 3] = drv_op[i];
    end
  end

  // Reference ALU: returns {zero, result}.
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  // External ALU stand-in.
  always_comb {alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_op);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t        sb[$];
  int          grant_q[$];
  int          rsp_cnt;
  logic [15:0] exp_cnt;

  // Monitor: push expectations at each grant, compare at each response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      grant_q.delete();
      rsp_cnt = 0;
      exp_cnt = 16'h0;
    end else begin
      if (preset_req) exp_cnt = 16'hFFFF;
      if (bus.req_ready != '0) begin
        check("grant_onehot", 64'($onehot(bus.req_ready)), 64'd1);
        for (int i = 0; i < N; i++) begin
          if (bus.req_ready[i]) begin
            sb.push_back('{i, alu_ref(drv_a[i], drv_b[i], drv_op[i])});
            grant_q.push_back(i);
          end
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        exp_t e;
        rsp_cnt++;
        exp_cnt = exp_cnt + 16'd1;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_id", 64'(bus.rsp_id), 64'(e.id));
          check("sb_result", 64'(bus.rsp_result), 64'(e.zr[W-1:0]));
          check("sb_zero", 64'(bus.rsp_zero), 64'(e.zr[W]));
        end
      end
    end
  end

  // One isolated op from requester v.id, with cycle-exact checks.
  task automatic do_single(input vec_t v);
    logic [N-1:0] g;
    g = '0;
    g[v.id] = 1'b1;
    drv_a[v.id]  = v.a;
    drv_b[v.id]  = v.b;
    drv_op[v.id] = v.op;
    drv_valid = g;
    @(negedge clk);
    check("c0_grant", 64'(bus.req_ready), 64'(g));
    check("c0_no_rsp", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    drv_valid = '0;
    @(negedge clk);
    check("c1_no_rsp", 64'(bus.rsp_valid), 64'd0);
    check("c1_no_ready", 64'(bus.req_ready), 64'd0);
    check("c1_alu_a", 64'(alu_a), 64'(v.a));
    check("c1_alu_b", 64'(alu_b), 64'(v.b));
    check("c1_alu_op", 64'(alu_op), 64'(v.op));
    @(posedge clk); #1;
    @(negedge clk);
    check("c2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("c2_rsp_id", 64'(bus.rsp_id), 64'(v.id));
    check("c2_rsp_result", 64'(bus.rsp_result), 64'(v.res));
    check("c2_rsp_zero", 64'(bus.rsp_zero), 64'(v.zero));
    check("c2_no_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("c3_rsp_done", 64'(bus.rsp_valid), 64'd0);
    check("c3_op_count", 64'(op_count), 64'(exp_cnt));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_valid = '0;
    rsp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'd5,          32'd3,          OP_ADD, 32'd8,          1'b0};
    vecs[1] = '{1, 32'd7,          32'd7,          OP_SUB, 32'd0,          1'b1};
    vecs[2] = '{2, 32'hF0F0_1234,  32'h0FF0_FFFF,  OP_AND, 32'h00F0_1234,  1'b0};
    vecs[3] = '{3, 32'h8000_0000,  32'h8000_0000,  OP_ADD, 32'd0,          1'b1};
    vecs[4] = '{0, 32'h0000_1200,  32'h0000_0034,  OP_OR,  32'h0000_1234,  1'b0};
    vecs[5] = '{1, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  OP_XOR, 32'h5555_5555,  1'b0};
    vecs[6] = '{2, 32'd3,          32'd5,          OP_SUB, 32'hFFFF_FFFE,  1'b0};
    vecs[7] = '{3, 32'd1,          32'd4,          OP_SLL, 32'd16,         1'b0};
    vecs[8] = '{0, 32'h0000_0080,  32'd3,          OP_SRL, 32'h0000_0010,  1'b0};
    vecs[9] = '{1, 32'hFFFF_FFFF,  32'd1,          OP_SLT, 32'd1,          1'b0};

    preset_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
      drv_op[i] = '0;
    end
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    @(posedge clk); #1;

    // Vector table: single ops from varying requesters.
    for (int i = 0; i < NV; i++) do_single(vecs[i]);
    check("table_op_count", 64'(op_count), 64'd10);

    // All four requesting: round-robin order from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) begin
      drv_a[i]  = 32'(i * 16 + 1);
      drv_b[i]  = 32'(i + 2);
      drv_op[i] = (i < 2) ? 3'(OP_ADD) : ((i == 2) ? 3'(OP_SUB) : 3'(OP_XOR));
    end
    drv_valid = '1;
    for (int c = 0; c < 200 && rsp_cnt < 8; c++) begin
      @(posedge clk); #1;
      if (grant_q.size() >= 8) drv_valid = '0;
    end
    drv_valid = '0;
    check("rr_rsp_count", 64'(rsp_cnt), 64'd8);
    check("rr_grant_count", 64'(grant_q.size()), 64'd8);
    for (int i = 0; i < grant_q.size() && i < 8; i++) begin
      check("rr_order", 64'(grant_q[i]), 64'(i % 4));
    end
    check("rr_op_count", 64'(op_count), 64'd8);
    @(posedge clk); #1;

    // Backpressure: response held five cycles with requester 1 waiting.
    drv_a[0] = 32'd100; drv_b[0] = 32'd23; drv_op[0] = OP_ADD;
    drv_a[1] = 32'd9;   drv_b[1] = 32'd4;  drv_op[1] = OP_SUB;
    rsp_rdy = 1'b0;
    drv_valid = 4'b0001;
    @(negedge clk);
    check("bp_grant0", 64'(bus.req_ready), 64'b0001);
    @(posedge clk); #1;
    drv_valid = 4'b0010;
    @(negedge clk);
    check("bp_issue_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rsp_id", 64'(bus.rsp_id), 64'd0);
      check("bp_rsp_result", 64'(bus.rsp_result), 64'd123);
      check("bp_rsp_zero", 64'(bus.rsp_zero), 64'd0);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_grant1", 64'(bus.req_ready), 64'b0010);
    check("bp_idle_no_rsp", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    drv_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_sb_drained", 64'(sb.size()), 64'd0);

    // Reset while an op is in ISSUE.
    drv_a[3] = 32'd1; drv_b[3] = 32'd2; drv_op[3] = OP_ADD;
    drv_valid = 4'b1000;
    @(negedge clk);
    check("mr_grant3", 64'(bus.req_ready), 64'b1000);
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    check("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mr_req_ready", 64'(bus.req_ready), 64'd0);
    check("mr_alu_a", 64'(alu_a), 64'd0);
    check("mr_alu_b", 64'(alu_b), 64'd0);
    check("mr_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("mr_op_count", 64'(op_count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_hold_no_rsp", 64'(bus.rsp_valid), 64'd0);
      check("mr_hold_no_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_single('{2, 32'd40, 32'd2, OP_ADD, 32'd42, 1'b0});

    // Counter wrap: preset to all ones, one more op returns it to zero.
    force dut.op_count = 16'hFFFF;
    #2;
    release dut.op_count;
    preset_req = 1'b1;
    @(posedge clk); #1;
    preset_req = 1'b0;
    check("wrap_preset", 64'(op_count), 64'hFFFF);
    do_single('{1, 32'd6, 32'd6, OP_XOR, 32'd0, 1'b1});
    check("wrap_zero", 64'(op_count), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
